// File: rtl/iir_pkg.sv
// Shared constants, FSM state type and saturation helper for the biquad cascade.
package iir_pkg;

    localparam int NUM_TAPS = 5;

    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;

    // Widest value the saturation helper can range-check.
    localparam int SAT_MAX_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        UPDATE,
        OUT
    } state_t;

    // True when value does not fit in a signed field of the given width.
    function automatic logic sat_clips(input logic signed [SAT_MAX_W-1:0] value,
                                       input int width);
        logic signed [SAT_MAX_W-1:0] lim;
        lim = SAT_MAX_W'(1) << (width - 1);
        return (value >= lim) || (value < -lim);
    endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// Shared multiply-accumulate unit: one signed product per cycle added to or
// subtracted from a wrapping accumulator, plus rescale and clip of the result.
module iir_mac_unit
    import iir_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COEFF_WIDTH = 32,
    parameter int ACC_WIDTH   = 64,
    parameter int SCALE_SHIFT = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          en,
    input  logic                          sub,
    input  logic signed [DATA_WIDTH-1:0]  mul_a,
    input  logic signed [COEFF_WIDTH-1:0] mul_b,
    output logic signed [DATA_WIDTH-1:0]  result,
    output logic                          clip
);

    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;

    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [SAT_MAX_W-1:0] shifted_ext;

    // Next accumulator value: clear wins, otherwise add or subtract the product.
    always_comb begin
        prod     = mul_a * mul_b;
        prod_ext = {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Drop the fractional bits and clamp to the sample range.
    always_comb begin
        shifted     = acc_q >>> SCALE_SHIFT;
        shifted_ext = {{(SAT_MAX_W-ACC_WIDTH){shifted[ACC_WIDTH-1]}}, shifted};
        clip        = sat_clips(shifted_ext, DATA_WIDTH);
        if (clip) begin
            result = shifted[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            result = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/iir_sos_cascade.sv
// Cascade of Direct-Form-I biquads evaluated one tap per cycle on a shared MAC,
// with loadable coefficients, per-section delay lines and valid/ready handshakes.
module iir_sos_cascade
    import iir_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int COEFF_WIDTH  = 32,
    parameter int ACC_WIDTH    = 64,
    parameter int SCALE_SHIFT  = 20,
    parameter int NUM_SECTIONS = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic signed [DATA_WIDTH-1:0]                 in_data,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic signed [DATA_WIDTH-1:0]                 out_data,
    input  logic                                         coef_we,
    input  logic [$clog2(NUM_TAPS*NUM_SECTIONS)-1:0]     coef_addr,
    input  logic signed [COEFF_WIDTH-1:0]                coef_wdata,
    input  logic                                         state_clr,
    input  logic                                         status_clr,
    output logic                                         sat_flag,
    output logic                                         coef_err
);

    localparam int NUM_COEFS = NUM_TAPS * NUM_SECTIONS;
    localparam int ADDR_W    = $clog2(NUM_COEFS);
    localparam int SEC_W     = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
    localparam logic [ADDR_W:0]               COEF_LIMIT = (ADDR_W+1)'(NUM_COEFS);
    localparam logic [SEC_W-1:0]              LAST_SEC   = SEC_W'(NUM_SECTIONS - 1);
    localparam logic signed [COEFF_WIDTH-1:0] COEF_UNITY = COEFF_WIDTH'(1) << SCALE_SHIFT;

    state_t                         state_q, state_d;
    logic [SEC_W-1:0]               sec_q, sec_d;
    logic [2:0]                     tap_q, tap_d;
    logic signed [DATA_WIDTH-1:0]   x_cur_q, x_cur_d;
    logic signed [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                           sat_flag_q, sat_flag_d;
    logic                           coef_err_q, coef_err_d;
    logic signed [COEFF_WIDTH-1:0]  coef_q [NUM_COEFS];
    logic signed [COEFF_WIDTH-1:0]  coef_d [NUM_COEFS];
    logic signed [DATA_WIDTH-1:0]   x1_q [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0]   x1_d [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0]   x2_q [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0]   x2_d [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0]   y1_q [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0]   y1_d [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0]   y2_q [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0]   y2_d [NUM_SECTIONS];

    logic [ADDR_W-1:0]              coef_idx;
    logic                           mac_clr, mac_en, mac_sub, mac_clip;
    logic signed [DATA_WIDTH-1:0]   mac_a, mac_result;
    logic signed [COEFF_WIDTH-1:0]  mac_b;
    logic                           sat_set, coef_drop, addr_ok;

    iir_mac_unit #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COEFF_WIDTH (COEFF_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH),
        .SCALE_SHIFT (SCALE_SHIFT)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (mac_clr),
        .en     (mac_en),
        .sub    (mac_sub),
        .mul_a  (mac_a),
        .mul_b  (mac_b),
        .result (mac_result),
        .clip   (mac_clip)
    );

    // Pick the coefficient and delay-line operand for the current section and tap.
    always_comb begin
        coef_idx = ADDR_W'(int'(sec_q) * NUM_TAPS + int'(tap_q));
        mac_b    = coef_q[coef_idx];
        mac_sub  = (tap_q == TAP_A1) || (tap_q == TAP_A2);
        case (tap_q)
            TAP_B1:  mac_a = x1_q[sec_q];
            TAP_B2:  mac_a = x2_q[sec_q];
            TAP_A1:  mac_a = y1_q[sec_q];
            TAP_A2:  mac_a = y2_q[sec_q];
            default: mac_a = x_cur_q;
        endcase
    end

    // Sequencing, coefficient writes, delay-line updates and sticky flags.
    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        tap_d      = tap_q;
        x_cur_d    = x_cur_q;
        out_data_d = out_data_q;
        coef_d     = coef_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        y1_d       = y1_q;
        y2_d       = y2_q;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        sat_set    = 1'b0;
        addr_ok    = ({1'b0, coef_addr} < COEF_LIMIT);
        coef_drop  = coef_we && ((state_q != IDLE) || !addr_ok);

        case (state_q)
            IDLE: begin
                if (state_clr) begin
                    for (int i = 0; i < NUM_SECTIONS; i++) begin
                        x1_d[i] = '0;
                        x2_d[i] = '0;
                        y1_d[i] = '0;
                        y2_d[i] = '0;
                    end
                end
                if (coef_we && addr_ok) begin
                    coef_d[coef_addr[ADDR_W-1:0]] = coef_wdata;
                end
                if (in_valid) begin
                    x_cur_d = in_data;
                    sec_d   = '0;
                    tap_d   = TAP_B0;
                    mac_clr = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (tap_q == TAP_A2) begin
                    state_d = UPDATE;
                end else begin
                    tap_d = tap_q + 3'd1;
                end
            end
            UPDATE: begin
                x2_d[sec_q] = x1_q[sec_q];
                x1_d[sec_q] = x_cur_q;
                y2_d[sec_q] = y1_q[sec_q];
                y1_d[sec_q] = mac_result;
                x_cur_d     = mac_result;
                sat_set     = mac_clip;
                if (sec_q == LAST_SEC) begin
                    out_data_d = mac_result;
                    state_d    = OUT;
                end else begin
                    sec_d   = sec_q + 1'b1;
                    tap_d   = TAP_B0;
                    mac_clr = 1'b1;
                    state_d = MAC;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        sat_flag_d = status_clr ? 1'b0 : sat_flag_q;
        if (sat_set) begin
            sat_flag_d = 1'b1;
        end
        coef_err_d = status_clr ? 1'b0 : coef_err_q;
        if (coef_drop) begin
            coef_err_d = 1'b1;
        end
    end

    // State register; reset restores passthrough coefficients and empty delay lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sec_q      <= '0;
            tap_q      <= TAP_B0;
            x_cur_q    <= '0;
            out_data_q <= '0;
            sat_flag_q <= 1'b0;
            coef_err_q <= 1'b0;
            for (int i = 0; i < NUM_COEFS; i++) begin
                coef_q[i] <= ((i % NUM_TAPS) == 0) ? COEF_UNITY : '0;
            end
            for (int i = 0; i < NUM_SECTIONS; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            tap_q      <= tap_d;
            x_cur_q    <= x_cur_d;
            out_data_q <= out_data_d;
            sat_flag_q <= sat_flag_d;
            coef_err_q <= coef_err_d;
            coef_q     <= coef_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign sat_flag  = sat_flag_q;
    assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_iir_sos_cascade.sv
// Scoreboard bench for the biquad cascade: an arithmetic reference model
// predicts every output sample, a monitor compares on each output handshake.
module tb_iir_sos_cascade;

    localparam int DW      = 32;
    localparam int CW      = 32;
    localparam int SS      = 20;
    localparam int NS      = 4;
    localparam int NC      = 5 * NS;
    localparam int AD      = $clog2(NC);
    localparam int TIMEOUT = 1000;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid, in_ready, out_valid, out_ready;
    logic signed [DW-1:0] in_data, out_data;
    logic                 coef_we, state_clr, status_clr, sat_flag, coef_err;
    logic [AD-1:0]        coef_addr;
    logic signed [CW-1:0] coef_wdata;

    int     checks = 0;
    int     errors = 0;
    longint exp_q[$];
    longint mc [NC];
    longint mx1 [NS], mx2 [NS], my1 [NS], my2 [NS];
    bit     m_sat;
    bit     rand_ready = 1'b0;

    iir_sos_cascade #(
        .DATA_WIDTH   (DW),
        .COEFF_WIDTH  (CW),
        .ACC_WIDTH    (64),
        .SCALE_SHIFT  (SS),
        .NUM_SECTIONS (NS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .state_clr  (state_clr),
        .status_clr (status_clr),
        .sat_flag   (sat_flag),
        .coef_err   (coef_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_clear_state();
        for (int s = 0; s < NS; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) mc[i] = ((i % 5) == 0) ? (longint'(1) << SS) : 0;
        model_clear_state();
        m_sat = 1'b0;
    endfunction

    // y = (b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2) / 2^SS, clamped, per section.
    function automatic longint model_step(input longint x);
        longint acc, r, cur;
        cur = x;
        for (int s = 0; s < NS; s++) begin
            acc = mc[5*s] * cur + mc[5*s+1] * mx1[s] + mc[5*s+2] * mx2[s]
                - mc[5*s+3] * my1[s] - mc[5*s+4] * my2[s];
            r = acc >>> SS;
            if (r > MAXV) begin r = MAXV; m_sat = 1'b1; end
            else if (r < MINV) begin r = MINV; m_sat = 1'b1; end
            mx2[s] = mx1[s]; mx1[s] = cur;
            my2[s] = my1[s]; my1[s] = r;
            cur = r;
        end
        return cur;
    endfunction

    // Monitor: compare each delivered sample with the oldest prediction.
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check_output("unexpected output sample", longint'(out_data), -1);
            else check_output("out_data", longint'(out_data), exp_q.pop_front());
        end
    end

    // Random downstream backpressure when enabled.
    always @(negedge clk) if (rand_ready) out_ready = 1'($urandom_range(0, 1));

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < TIMEOUT) begin @(negedge clk); n++; end
        if (!in_ready) check_output("wait idle timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < TIMEOUT) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) check_output("drain timeout pending", exp_q.size(), 0);
    endtask

    task automatic apply_stimulus(input longint d);
        int n = 0;
        @(negedge clk);
        in_data  = DW'(d);
        in_valid = 1'b1;
        while (!in_ready && n < TIMEOUT) begin @(negedge clk); n++; end
        if (in_ready) begin
            exp_q.push_back(model_step(d));
            @(posedge clk);
        end else begin
            check_output("accept timeout", 0, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic write_coef(input int addr, input longint data);
        wait_idle();
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = AD'(addr);
        coef_wdata = CW'(data);
        if (addr < NC) mc[addr] = data;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic clear_state();
        wait_idle();
        @(negedge clk);
        state_clr = 1'b1;
        model_clear_state();
        @(negedge clk);
        state_clr = 1'b0;
    endtask

    task automatic pulse_status_clr();
        @(negedge clk);
        status_clr = 1'b1;
        m_sat = 1'b0;
        @(negedge clk);
        status_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired: checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int    lat;
        logic signed [DW-1:0] held;
        int    n;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        state_clr = 1'b0; status_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("reset in_ready", in_ready, 1);
        check_output("reset out_valid", out_valid, 0);
        check_output("reset out_data", longint'(out_data), 0);
        check_output("reset sat_flag", sat_flag, 0);
        check_output("reset coef_err", coef_err, 0);

        // Passthrough and latency
        apply_stimulus(1000);
        check_output("in_ready while busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin @(posedge clk); lat++; @(negedge clk); end
        check_output("latency to out_valid", lat + 1, 6 * NS + 1);
        wait_drain();
        check_output("passthrough sat_flag", sat_flag, 0);

        // One-pole feedback impulse response, then state_clr
        clear_state();
        write_coef(3, -(longint'(1) << 19));
        apply_stimulus(1024);
        apply_stimulus(0);
        apply_stimulus(0);
        apply_stimulus(0);
        wait_drain();
        clear_state();
        apply_stimulus(0);
        wait_drain();

        // Saturation and status clear
        write_coef(3, 0);
        write_coef(0, longint'(4) << 20);
        clear_state();
        apply_stimulus(64'sh7000_0000);
        wait_drain();
        check_output("sat_flag after clip", sat_flag, 1);
        pulse_status_clr();
        check_output("sat_flag after status_clr", sat_flag, 0);
        write_coef(0, longint'(1) << 20);

        // Backpressure: output held, no second accept until handshake
        out_ready = 1'b0;
        apply_stimulus(1234);
        n = 0;
        while (!out_valid && n < TIMEOUT) begin @(negedge clk); n++; end
        check_output("backpressure out_valid", out_valid, 1);
        held = out_data;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check_output("held out_data", longint'(out_data), longint'(held));
                    check_output("held in_ready", in_ready, 0);
                    check_output("held out_valid", out_valid, 1);
                end
                out_ready = 1'b1;
            end
            apply_stimulus(-55);
        join
        wait_drain();

        // Coefficient write during MAC is dropped
        apply_stimulus(300);
        coef_we = 1'b1; coef_addr = AD'(0); coef_wdata = CW'(longint'(7) << 20);
        @(negedge clk);
        coef_we = 1'b0;
        check_output("coef_err busy write", coef_err, 1);
        wait_drain();
        pulse_status_clr();
        check_output("coef_err cleared", coef_err, 0);
        write_coef(19, 0);
        check_output("coef_err last valid addr", coef_err, 0);
        write_coef(20, 123);
        check_output("coef_err addr out of range", coef_err, 1);
        pulse_status_clr();
        @(negedge clk);
        coef_we = 1'b1; coef_addr = AD'(25); status_clr = 1'b1;
        @(negedge clk);
        coef_we = 1'b0; status_clr = 1'b0;
        check_output("coef_err set beats clear", coef_err, 1);
        pulse_status_clr();

        // Write and accept in the same idle cycle
        wait_idle();
        @(negedge clk);
        coef_we = 1'b1; coef_addr = AD'(15); coef_wdata = CW'(longint'(2) << 20);
        in_valid = 1'b1; in_data = DW'(400);
        mc[15] = longint'(2) << 20;
        exp_q.push_back(model_step(400));
        @(negedge clk);
        coef_we = 1'b0; in_valid = 1'b0;
        wait_drain();
        write_coef(15, longint'(1) << 20);

        // Randomized coefficients, samples and backpressure
        rand_ready = 1'b1;
        for (int round = 0; round < 3; round++) begin
            for (int a = 0; a < NC; a++) begin
                if ((a % 5) < 3) write_coef(a, longint'($urandom_range(0, 2 << 20)) - (1 << 20));
                else write_coef(a, longint'($urandom_range(0, 1 << 19)) - (1 << 18));
            end
            clear_state();
            for (int k = 0; k < 8; k++) apply_stimulus(longint'($urandom_range(0, 1 << 25)) - (1 << 24));
            wait_drain();
        end
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        wait_drain();

        // Reset in the middle of a computation
        write_coef(0, longint'(3) << 20);
        apply_stimulus(500);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        check_output("mid reset out_valid", out_valid, 0);
        check_output("mid reset sat_flag", sat_flag, 0);
        check_output("mid reset coef_err", coef_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check_output("after reset in_ready", in_ready, 1);
        apply_stimulus(777);
        wait_drain();

        check_output("scoreboard empty at end", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
